arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Requester-side agent for the 3-way fixed-priority arbiter. It drives one arbiter request line (`r1`/`r2`/`r3`) and consumes the matching grant (`g1`/`g2`/`g3`).
- It queues jobs. Each job is a count of grant-qualified beats. For each job it raises `req`, holds it until the job's beats complete, then releases the resource for a fixed idle gap.
- One instance sits in front of each arbiter port, so the arbiter sees well-behaved, bounded requests.

Parameters:
- `LEN_W`, 4: width of `job_len`; maximum job length is 2^LEN_W-1 beats.
- `DEPTH`, 4: job FIFO depth, in entries; power of two, ≥2.
- `GAP`, 1: idle cycles with `req`=0 after each job; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `job_valid`  in  1  job offered this cycle.
- `job_len`  in  LEN_W  beats requested by the offered job.
- `job_ready`  out  1  FIFO can accept a job.
- `req`  out  1  request to arbiter (connects to `rN`); registered.
- `gnt`  in  1  grant from arbiter (connects to `gN`); combinational from `req`.
- `active`  out  1  a job is in progress (state OWN); registered.
- `beat`  out  1  combinational: `active` & `gnt`; marks one transferred beat.
- `remaining`  out  LEN_W  beats left in the current job, including the current beat; registered.
- `done`  out  1  one-cycle pulse after a job's last beat; registered.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: a cycle with `rst_n`=0 at the clock edge produces the following on the next edge:
  - state IDLE;
  - FIFO flushed, `pending`=0;
  - `req`=0, `active`=0, `remaining`=0, `done`=0;
  - `job_ready`=1 in the following cycle.
  - Reset is honoured mid-job: the job in progress and all queued jobs are discarded with no `done` pulse.
- Enqueue:
  - A job is accepted when `job_valid`&`job_ready`.
  - `job_ready` = (`pending` < DEPTH); it does not depend on a same-cycle pop.
  - A `job_len` of 0 is accepted and dropped: it is not enqueued and produces no request.
  - A simultaneous push and pop leaves `pending` unchanged.
- States:
  - IDLE: `req`=0. If `pending`>0, go to REQ; `req`=1 from the next cycle.
  - REQ: `req`=1, `active`=0. On `gnt`=1:
    - pop the FIFO head;
    - load `remaining` ← head length;
    - go to OWN, with `active`=1 next cycle.
    - While `gnt`=0, stay in REQ indefinitely with `req` held at 1.
  - OWN: `req`=1 throughout; the block never drops `req` before the job ends.
    - Each cycle with `gnt`=1 is one beat, and `remaining` decrements.
    - A cycle with `gnt`=0 (preempted by a higher-priority requester) is a stall: no decrement, stay in OWN.
    - When a beat occurs with `remaining`=1, go to GAP on the next edge with `req`=0, `active`=0, `remaining`=0, and `done`=1 for exactly that one cycle.
  - GAP: `req`=0 for exactly GAP cycles, counted from the first cycle in GAP. After that, go to IDLE, or straight to REQ if `pending`>0. Back-to-back jobs therefore see `req` low for exactly GAP cycles.
- Latency and timing:
  - A job pushed into an empty FIFO while in IDLE has `req`=1 two cycles after the accept edge (push edge, then the IDLE→REQ edge).
  - The grant cycle in REQ does not count as a beat.
  - Total ownership is `job_len` beat cycles plus any stall cycles.
- The arbiter's output is combinational, so `gnt` is valid only while `req`=1. `gnt`=1 while `req`=0 is ignored.

Test Plan:
- Push `job_len`=3 at t0 with `gnt` tied to `req`:
  - `req` rises 2 cycles later;
  - 1 grant cycle, then 3 beats with `remaining` 3→2→1;
  - `done` pulses once;
  - `req` stays low for 1 cycle;
  - `pending` returns to 0.
- Push 4 jobs (len 2 each) back-to-back, then a 5th while full:
  - `job_ready`=0 when `pending`=4, and the 5th job is not accepted;
  - the 4 jobs complete in order with 4 `done` pulses;
  - `req` drops for exactly GAP=1 cycle between jobs.
- Preemption: job len 4; force `gnt`=0 for 2 cycles after the 2nd beat:
  - `remaining` holds at 2, `req` stays 1;
  - job completes with 4 beats total, ownership spanning 6 cycles.
- Starvation: job len 2 with `gnt`=0 for 20 cycles:
  - `req` held at 1 and state REQ throughout;
  - no beats, no `done`.
  - Releasing `gnt` lets the job complete normally.
- Zero-length job:
  - push `job_len`=0: `pending` stays 0, `req` never rises;
  - push `job_len`=1 next: one beat, then `done`.
- Reset mid-job: `rst_n`=0 for one cycle during OWN with `remaining`=2 and `pending`=2:
  - the next edge shows `req`=0, `active`=0, `pending`=0, no `done` pulse;
  - a new job afterwards runs normally.

Source files
------------

// File: rtl/arb_requester.sv
// Requester-side agent for one port of a fixed-priority arbiter: queues jobs of
// N grant-qualified beats, holds req for each job, then idles for GAP cycles.
module arb_requester #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       job_valid,
    input  logic [LEN_W-1:0]           job_len,
    output logic                       job_ready,
    output logic                       req,
    input  logic                       gnt,
    output logic                       active,
    output logic                       beat,
    output logic [LEN_W-1:0]           remaining,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OWN,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               req_q, req_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   fifo_mem [DEPTH];
    logic [LEN_W-1:0]   head_len;
    logic               push;
    logic               pop;

    assign job_ready = (count_q < CNT_W'(DEPTH));
    // Zero-length jobs are accepted on the handshake but never stored.
    assign push      = job_valid & job_ready & (job_len != '0);
    assign pop       = (state_q == S_REQ) & gnt;
    assign head_len  = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= job_len;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The grant cycle only takes ownership; beats start next cycle.
                if (gnt) begin
                    state_d     = S_OWN;
                    remaining_d = head_len;
                end
            end
            S_OWN: begin
                if (gnt) begin
                    if (remaining_q == LEN_W'(1)) begin
                        state_d     = S_GAP;
                        remaining_d = '0;
                        done_d      = 1'b1;
                        gap_cnt_d   = GAP_W'(GAP - 1);
                    end else begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = (count_q != '0) ? S_REQ : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d    = (state_d == S_REQ) || (state_d == S_OWN);
        active_d = (state_d == S_OWN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            req_q       <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            req_q       <= req_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign req       = req_q;
    assign active    = active_q;
    assign beat      = active_q & gnt;
    assign remaining = remaining_q;
    assign done      = done_q;
    assign pending   = count_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed, table-driven bench for arb_requester (LEN_W=4, DEPTH=4, GAP=1).
module tb_arb_requester;

    logic       clk;
    logic       rst_n;
    logic       job_valid;
    logic [3:0] job_len;
    logic       job_ready;
    logic       req;
    logic       gnt;
    logic       active;
    logic       beat;
    logic [3:0] remaining;
    logic       done;
    logic [2:0] pending;

    int checks   = 0;
    int failures = 0;

    arb_requester #(.LEN_W(4), .DEPTH(4), .GAP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .req       (req),
        .gnt       (gnt),
        .active    (active),
        .beat      (beat),
        .remaining (remaining),
        .done      (done),
        .pending   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One row = inputs driven during a cycle plus the outputs expected in that same cycle.
    typedef struct packed {
        logic       rst_n;
        logic       jv;
        logic [3:0] jl;
        logic       g;
        logic       req;
        logic       act;
        logic       beat;
        logic [3:0] rem;
        logic       done;
        logic [2:0] pend;
        logic       rdy;
    } vec_t;

    function automatic vec_t mk(bit r, bit jv, int jl, bit g,
                                bit eq, bit ea, bit eb, int er, bit ed, int ep, bit ey);
        vec_t v;
        v.rst_n = r;
        v.jv    = jv;
        v.jl    = 4'(jl);
        v.g     = g;
        v.req   = eq;
        v.act   = ea;
        v.beat  = eb;
        v.rem   = 4'(er);
        v.done  = ed;
        v.pend  = 3'(ep);
        v.rdy   = ey;
        return v;
    endfunction

    task automatic run_row(input vec_t v, input string tag);
        logic [11:0] got;
        logic [11:0] exp;
        @(negedge clk);
        rst_n     = v.rst_n;
        job_valid = v.jv;
        job_len   = v.jl;
        gnt       = v.g;
        #1;
        got = {req, active, beat, remaining, done, pending, job_ready};
        exp = {v.req, v.act, v.beat, v.rem, v.done, v.pend, v.rdy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got req=%b act=%b beat=%b rem=%0d done=%b pend=%0d rdy=%b, need req=%b act=%b beat=%b rem=%0d done=%b pend=%0d rdy=%b",
                     tag, req, active, beat, remaining, done, pending, job_ready,
                     v.req, v.act, v.beat, v.rem, v.done, v.pend, v.rdy);
        end else begin
            $display("ok   %s: req=%b act=%b beat=%b rem=%0d done=%b pend=%0d rdy=%b",
                     tag, req, active, beat, remaining, done, pending, job_ready);
        end
    endtask

    vec_t tbl[$];

    initial begin
        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_len   = '0;
        gnt       = 1'b0;
        repeat (2) @(posedge clk);

        // Single job len 3, gnt always high (also high while req=0, must be ignored).
        tbl.push_back(mk(1,1,3,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0,1, 1,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0,1, 1,1,1,3,0,0,1));
        tbl.push_back(mk(1,0,0,1, 1,1,1,2,0,0,1));
        tbl.push_back(mk(1,0,0,1, 1,1,1,1,0,0,1));
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,1,0,1));
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,0,0,1));
        // Fill FIFO with four len-2 jobs while starved, then offer a fifth while full.
        tbl.push_back(mk(1,1,2,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,1,2,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(1,1,2,0, 1,0,0,0,0,2,1));
        tbl.push_back(mk(1,1,2,0, 1,0,0,0,0,3,1));
        tbl.push_back(mk(1,1,5,0, 1,0,0,0,0,4,0));
        tbl.push_back(mk(1,0,0,1, 1,0,0,0,0,4,0));
        for (int j = 3; j >= 0; j--) begin
            tbl.push_back(mk(1,0,0,1, 1,1,1,2,0,j,1));
            tbl.push_back(mk(1,0,0,1, 1,1,1,1,0,j,1));
            tbl.push_back(mk(1,0,0,1, 0,0,0,0,1,j,1));
            if (j > 0) begin
                tbl.push_back(mk(1,0,0,1, 1,0,0,0,0,j,1));
            end
        end
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,0,0,1));
        // Zero-length job is dropped, then a len-1 job runs one beat.
        tbl.push_back(mk(1,1,0,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,1,1,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0,1, 1,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0,1, 1,1,1,1,0,0,1));
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,1,0,1));
        tbl.push_back(mk(1,0,0,1, 0,0,0,0,0,0,1));

        foreach (tbl[i]) begin
            run_row(tbl[i], $sformatf("table[%0d]", i));
        end

        // Preemption: len 4, two stall cycles after the second beat.
        run_row(mk(1,1,4,1, 0,0,0,0,0,0,1), "preempt push");
        run_row(mk(1,0,0,1, 0,0,0,0,0,1,1), "preempt idle");
        run_row(mk(1,0,0,1, 1,0,0,0,0,1,1), "preempt grant");
        run_row(mk(1,0,0,1, 1,1,1,4,0,0,1), "preempt beat1");
        run_row(mk(1,0,0,1, 1,1,1,3,0,0,1), "preempt beat2");
        run_row(mk(1,0,0,0, 1,1,0,2,0,0,1), "preempt stall1");
        run_row(mk(1,0,0,0, 1,1,0,2,0,0,1), "preempt stall2");
        run_row(mk(1,0,0,1, 1,1,1,2,0,0,1), "preempt beat3");
        run_row(mk(1,0,0,1, 1,1,1,1,0,0,1), "preempt beat4");
        run_row(mk(1,0,0,1, 0,0,0,0,1,0,1), "preempt done");
        run_row(mk(1,0,0,1, 0,0,0,0,0,0,1), "preempt idle2");

        // Starvation: 20 cycles with no grant, then release.
        run_row(mk(1,1,2,0, 0,0,0,0,0,0,1), "starve push");
        run_row(mk(1,0,0,0, 0,0,0,0,0,1,1), "starve idle");
        for (int i = 0; i < 20; i++) begin
            run_row(mk(1,0,0,0, 1,0,0,0,0,1,1), $sformatf("starve wait[%0d]", i));
        end
        run_row(mk(1,0,0,1, 1,0,0,0,0,1,1), "starve grant");
        run_row(mk(1,0,0,1, 1,1,1,2,0,0,1), "starve beat1");
        run_row(mk(1,0,0,1, 1,1,1,1,0,0,1), "starve beat2");
        run_row(mk(1,0,0,1, 0,0,0,0,1,0,1), "starve done");
        run_row(mk(1,0,0,1, 0,0,0,0,0,0,1), "starve idle2");

        // Reset during OWN with remaining=2 and two jobs still queued.
        run_row(mk(1,1,3,0, 0,0,0,0,0,0,1), "rst push1");
        run_row(mk(1,1,3,0, 0,0,0,0,0,1,1), "rst push2");
        run_row(mk(1,1,3,0, 1,0,0,0,0,2,1), "rst push3");
        run_row(mk(1,0,0,1, 1,0,0,0,0,3,1), "rst grant");
        run_row(mk(1,0,0,1, 1,1,1,3,0,2,1), "rst beat1");
        run_row(mk(0,0,0,1, 1,1,1,2,0,2,1), "rst assert");
        run_row(mk(1,0,0,1, 0,0,0,0,0,0,1), "rst cleared");
        run_row(mk(1,1,1,1, 0,0,0,0,0,0,1), "rst newjob push");
        run_row(mk(1,0,0,1, 0,0,0,0,0,1,1), "rst newjob idle");
        run_row(mk(1,0,0,1, 1,0,0,0,0,1,1), "rst newjob grant");
        run_row(mk(1,0,0,1, 1,1,1,1,0,0,1), "rst newjob beat");
        run_row(mk(1,0,0,1, 0,0,0,0,1,0,1), "rst newjob done");
        run_row(mk(1,0,0,1, 0,0,0,0,0,0,1), "rst newjob idle2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
